alu_share_arbiter: RTL and testbench

- Shares one instance of the core's 32-bit ALU (ops ADD 000, SUB 001, AND 010, OR 011, SLT 101; all other codes give 0) between two requesters.
- Port 0 is the main datapath side; port 1 is an auxiliary unit, e.g. a debug or iterative-op engine.
- Round-robin arbitration, valid/ready request handshake, registered operands and registered result.
- The ALU is instantiated outside this block and connected through its SrcA/SrcB/ALUControl/ALUResult/Zero pins.

---
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external ALU between two valid/ready requesters.
// Operands are registered toward the ALU, and the result is registered back to the requester.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0SrcA,
  input  logic [WIDTH-1:0] Req0SrcB,
  input  logic [2:0]       Req0ALUControl,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1SrcA,
  input  logic [WIDTH-1:0] Req1SrcB,
  input  logic [2:0]       Req1ALUControl,
  output logic             Resp0Valid,
  input  logic             Resp0Ready,
  output logic             Resp1Valid,
  input  logic             Resp1Ready,
  output logic [WIDTH-1:0] RespResult,
  output logic             RespZero,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic             owner_reg, owner_next;
  logic [WIDTH-1:0] src_a_reg, src_a_next;
  logic [WIDTH-1:0] src_b_reg, src_b_next;
  logic [2:0]       alu_control_reg, alu_control_next;
  logic [WIDTH-1:0] resp_result_reg, resp_result_next;
  logic             resp_zero_reg, resp_zero_next;

  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [WIDTH-1:0] req_src_a [2];
  logic [WIDTH-1:0] req_src_b [2];
  logic [2:0]       req_op [2];
  logic             grant, grant_valid;

  assign req_valid    = {Req1Valid, Req0Valid};
  assign resp_ready   = {Resp1Ready, Resp0Ready};
  assign req_src_a[0] = Req0SrcA;
  assign req_src_a[1] = Req1SrcA;
  assign req_src_b[0] = Req0SrcB;
  assign req_src_b[1] = Req1SrcB;
  assign req_op[0]    = Req0ALUControl;
  assign req_op[1]    = Req1ALUControl;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_valid = (state_reg == IDLE) && (|req_valid);
    grant       = (&req_valid) ? ~last_grant_reg : req_valid[1];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi]  = grant_valid && (grant == 1'(gi));
      assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    owner_next       = owner_reg;
    src_a_next       = src_a_reg;
    src_b_next       = src_b_reg;
    alu_control_next = alu_control_reg;
    resp_result_next = resp_result_reg;
    resp_zero_next   = resp_zero_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          src_a_next       = req_src_a[grant];
          src_b_next       = req_src_b[grant];
          alu_control_next = req_op[grant];
          owner_next       = grant;
          last_grant_next  = grant;
          state_next       = EXEC;
        end
      end
      EXEC: begin
        resp_result_next = ALUResult;
        resp_zero_next   = Zero;
        state_next       = RESP;
      end
      RESP: begin
        if (resp_ready[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      owner_reg       <= 1'b0;
      src_a_reg       <= '0;
      src_b_reg       <= '0;
      alu_control_reg <= 3'b000;
      resp_result_reg <= '0;
      resp_zero_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      owner_reg       <= owner_next;
      src_a_reg       <= src_a_next;
      src_b_reg       <= src_b_next;
      alu_control_reg <= alu_control_next;
      resp_result_reg <= resp_result_next;
      resp_zero_reg   <= resp_zero_next;
    end
  end

  assign Req0Ready  = req_ready[0];
  assign Req1Ready  = req_ready[1];
  assign Resp0Valid = resp_valid[0];
  assign Resp1Valid = resp_valid[1];
  assign RespResult = resp_result_reg;
  assign RespZero   = resp_zero_reg;
  assign SrcA       = src_a_reg;
  assign SrcB       = src_b_reg;
  assign ALUControl = alu_control_reg;
  assign Busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random transactions,
// checked against a transaction-level arbitration model and a behavioural ALU.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 0;
  logic reset;
  logic Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [W-1:0] Req0SrcA, Req0SrcB, Req1SrcA, Req1SrcB;
  logic [2:0] Req0ALUControl, Req1ALUControl;
  logic Resp0Valid, Resp0Ready, Resp1Valid, Resp1Ready;
  logic [W-1:0] RespResult, SrcA, SrcB, ALUResult;
  logic RespZero, Zero, Busy;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0SrcA(Req0SrcA),
    .Req0SrcB(Req0SrcB), .Req0ALUControl(Req0ALUControl),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1SrcA(Req1SrcA),
    .Req1SrcB(Req1SrcB), .Req1ALUControl(Req1ALUControl),
    .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready),
    .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready),
    .RespResult(RespResult), .RespZero(RespZero),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero), .Busy(Busy)
  );

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Behavioural stand-in for the core's ALU.
  assign ALUResult = alu_fn(ALUControl, SrcA, SrcB);
  assign Zero      = (ALUResult == '0);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Requester model: pending flags and payloads per port, plus the last granted port.
  bit pend[2];
  logic [W-1:0] pa[2], pb[2];
  logic [2:0] pop[2];
  int last_g;

  task automatic drive_reqs();
    Req0Valid = pend[0]; Req0SrcA = pa[0]; Req0SrcB = pb[0]; Req0ALUControl = pop[0];
    Req1Valid = pend[1]; Req1SrcA = pa[1]; Req1SrcB = pb[1]; Req1ALUControl = pop[1];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[p] = 1; pop[p] = op; pa[p] = a; pb[p] = b;
  endtask

  // One full transaction from the IDLE state; hold = cycles the owner withholds ready.
  task automatic txn(input int hold, output int g, output logic [W-1:0] res, output logic zr);
    logic [W-1:0] er;
    logic ez;
    if (pend[0] && pend[1]) g = 1 - last_g;
    else g = pend[0] ? 0 : 1;
    er = alu_fn(pop[g], pa[g], pb[g]);
    ez = (er == '0);
    drive_reqs(); #1;
    chk("req0_ready_idle", {31'b0, Req0Ready}, {31'b0, g == 0});
    chk("req1_ready_idle", {31'b0, Req1Ready}, {31'b0, g == 1});
    tick();
    pend[g] = 0; last_g = g; drive_reqs();
    #1;
    chk("busy_exec", {31'b0, Busy}, 1);
    chk("ready_exec", {30'b0, Req1Ready, Req0Ready}, 0);
    chk("respv_exec", {30'b0, Resp1Valid, Resp0Valid}, 0);
    tick();
    for (int i = 0; i <= hold; i++) begin
      chk("resp0_valid", {31'b0, Resp0Valid}, {31'b0, g == 0});
      chk("resp1_valid", {31'b0, Resp1Valid}, {31'b0, g == 1});
      chk("resp_result", RespResult, er);
      chk("resp_zero", {31'b0, RespZero}, {31'b0, ez});
      chk("ready_resp", {30'b0, Req1Ready, Req0Ready}, 0);
      if (i < hold) begin
        Resp0Ready = (g == 1); Resp1Ready = (g == 0);
        tick();
      end
    end
    res = RespResult; zr = RespZero;
    Resp0Ready = (g == 0); Resp1Ready = (g == 1);
    tick();
    Resp0Ready = 0; Resp1Ready = 0;
    #1;
    chk("busy_done", {31'b0, Busy}, 0);
    chk("respv_done", {30'b0, Resp1Valid, Resp0Valid}, 0);
    $display("txn port=%0d op=%0d a=0x%08h b=0x%08h result=0x%08h zero=%0d", g, pop[g], pa[g], pb[g], res, zr);
  endtask

  task automatic do_reset();
    reset = 1;
    pend[0] = 0; pend[1] = 0; last_g = 1;
    drive_reqs();
    tick(); tick();
    reset = 0;
    #1;
  endtask

  initial begin
    int g;
    logic [W-1:0] res;
    logic zr;
    Resp0Ready = 0; Resp1Ready = 0;
    pa[0] = 0; pb[0] = 0; pop[0] = 0; pa[1] = 0; pb[1] = 0; pop[1] = 0;
    do_reset();
    chk("rst_busy", {31'b0, Busy}, 0);
    chk("rst_ready", {30'b0, Req1Ready, Req0Ready}, 0);
    chk("rst_respv", {30'b0, Resp1Valid, Resp0Valid}, 0);
    chk("rst_result", RespResult, 0);
    chk("rst_zero", {31'b0, RespZero}, 0);
    chk("rst_srca", SrcA, 0);
    chk("rst_srcb", SrcB, 0);
    chk("rst_op", {29'b0, ALUControl}, 0);

    // Port 0 SUB 7-5, result held for 3 cycles.
    set_req(0, 3'b001, 7, 5);
    txn(3, g, res, zr);
    chk("sub_port", g, 0); chk("sub_result", res, 2); chk("sub_zero", {31'b0, zr}, 0);

    // Tie from reset: port 0 first, then port 1, then port 0 again.
    do_reset();
    set_req(0, 3'b000, 3, 4);
    set_req(1, 3'b101, 2, 9);
    txn(0, g, res, zr);
    chk("tie1_port", g, 0); chk("tie1_result", res, 7);
    txn(1, g, res, zr);
    chk("tie2_port", g, 1); chk("tie2_result", res, 1);
    set_req(0, 3'b011, 8, 1);
    set_req(1, 3'b000, 1, 1);
    txn(0, g, res, zr);
    chk("tie3_port", g, 0); chk("tie3_result", res, 9);
    txn(0, g, res, zr);
    chk("tie4_port", g, 1); chk("tie4_result", res, 2);

    // Port 1 AND giving zero; port 0 ready is ignored while port 1 owns.
    set_req(1, 3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F);
    txn(2, g, res, zr);
    chk("and_port", g, 1); chk("and_result", res, 0); chk("and_zero", {31'b0, zr}, 1);

    // Unsupported opcode.
    set_req(0, 3'b111, 32'hFFFFFFFF, 32'h12345678);
    txn(0, g, res, zr);
    chk("op7_result", res, 0); chk("op7_zero", {31'b0, zr}, 1);

    // Reset during EXEC drops the transaction.
    set_req(0, 3'b000, 32'h11, 32'h22);
    drive_reqs(); #1;
    chk("midrst_ready", {31'b0, Req0Ready}, 1);
    tick();
    pend[0] = 0; drive_reqs();
    reset = 1;
    tick();
    reset = 0; last_g = 1;
    #1;
    chk("midrst_busy", {31'b0, Busy}, 0);
    chk("midrst_result", RespResult, 0);
    chk("midrst_srca", SrcA, 0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_resp", {30'b0, Resp1Valid, Resp0Valid}, 0);
      tick();
    end
    set_req(0, 3'b011, 1, 2);
    txn(0, g, res, zr);
    chk("or_result", res, 3);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(1) == 1)) begin
          set_req(p, 3'($urandom_range(7)),
                  ($urandom_range(3) == 0) ? W'($urandom_range(3)) : W'($urandom),
                  ($urandom_range(3) == 0) ? W'($urandom_range(3)) : W'($urandom));
        end
      end
      if (!pend[0] && !pend[1]) set_req(t % 2, 3'b001, W'(t), W'(t));
      txn($urandom_range(3), g, res, zr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
